// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: RAM handshake states, data words and
// the arbiter state and requester-index types.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Default system size; the requester index covers d0, i0, d1, i1, ...
    localparam int ARB_CPUS  = 2;
    localparam int ARB_N     = 2 * ARB_CPUS;
    localparam int ARB_IDX_W = $clog2(ARB_N);
    typedef logic [ARB_IDX_W-1:0] arb_idx_t;

    // Requester number of core c's dcache (icache is this plus one).
    function automatic int dcache_req_id(input int c);
        return 2 * c;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr,
// wrapping modulo N. Shared with the bus snoop arbiter.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        // NOTE: every output gets a default before any conditional write so no latch is inferred.
        idx   = ptr;
        valid = 1'b0;
        // Scan farthest-first so the candidate nearest to ptr is the last write and wins.
        for (int i = N - 1; i >= 0; i--) begin
            int cand;
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand]) begin
                idx   = IDX_W'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Multi-core RAM arbiter: round-robin shares one RAM port among CPUS
// dcaches and CPUS icaches, holding each grant until the RAM reports ACCESS.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic      [CPUS-1:0] iREN,
    input  word_t     [CPUS-1:0] iaddr,
    input  logic      [CPUS-1:0] dREN,
    input  logic      [CPUS-1:0] dWEN,
    input  word_t     [CPUS-1:0] daddr,
    input  word_t     [CPUS-1:0] dstore,
    output logic      [CPUS-1:0] iwait,
    output logic      [CPUS-1:0] dwait,
    output word_t     [CPUS-1:0] iload,
    output word_t     [CPUS-1:0] dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate
);

    localparam int N     = 2 * CPUS;
    localparam int IDX_W = $clog2(N);
    typedef logic [IDX_W-1:0] idx_t;

    arb_state_t   state, state_next;
    idx_t         grant, grant_next;
    idx_t         ptr, ptr_next;
    logic [N-1:0] req;
    idx_t         pick_idx;
    logic         pick_valid;
    logic         done;

    always_comb begin
        for (int c = 0; c < CPUS; c++) begin
            req[dcache_req_id(c)]     = dREN[c] | dWEN[c];
            req[dcache_req_id(c) + 1] = iREN[c];
        end
    end

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A transfer completes only while the granted requester still asks for it.
    assign done = (state == XFER) && req[grant] && (ramstate == ACCESS);

    always_ff @(posedge CLK) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        iwait      = '1;
        dwait      = '1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_next = pick_idx;
                    state_next = XFER;
                end
            end
            XFER: begin
                for (int c = 0; c < CPUS; c++) begin
                    if (grant == idx_t'(dcache_req_id(c))) begin
                        ramaddr  = daddr[c];
                        ramstore = dstore[c];
                        ramWEN   = dWEN[c];
                        ramREN   = dREN[c] & ~dWEN[c];
                        dload[c] = ramload;
                        dwait[c] = ~done;
                    end
                    if (grant == idx_t'(dcache_req_id(c) + 1)) begin
                        ramaddr  = iaddr[c];
                        ramREN   = iREN[c];
                        iload[c] = ramload;
                        iwait[c] = ~done;
                    end
                end
                // Withdrawal returns to IDLE without moving ptr; FREE/BUSY/ERROR hold.
                if (!req[grant]) begin
                    state_next = IDLE;
                end else if (done) begin
                    state_next = IDLE;
                    ptr_next   = (grant == idx_t'(N - 1)) ? '0 : grant + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed corner cases, then
// randomized traffic scored against a transaction-level round-robin model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;
    localparam int N    = 2 * CPUS;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic      [CPUS-1:0]  iREN, dREN, dWEN, iwait, dwait;
    word_t     [CPUS-1:0]  iaddr, daddr, dstore, iload, dload;
    logic                  ramREN, ramWEN;
    word_t                 ramaddr, ramstore, ramload;
    ramstate_t             ramstate;

    memory_arbiter #(.CPUS(CPUS)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    // Requester-level stimulus, indexed d0, i0, d1, i1.
    logic  t_req  [N];
    logic  t_wr   [N];
    logic  t_both [N];
    word_t t_addr [N];
    word_t t_data [N];

    always_comb begin
        for (int c = 0; c < CPUS; c++) begin
            dREN[c]   = t_req[2*c] & (~t_wr[2*c] | t_both[2*c]);
            dWEN[c]   = t_req[2*c] & t_wr[2*c];
            daddr[c]  = t_addr[2*c];
            dstore[c] = t_data[2*c];
            iREN[c]   = t_req[2*c+1];
            iaddr[c]  = t_addr[2*c+1];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_reqs();
        for (int r = 0; r < N; r++) begin
            t_req[r]  = 1'b0;
            t_wr[r]   = 1'b0;
            t_both[r] = 1'b0;
        end
    endtask

    task automatic reset_dut();
        clear_reqs();
        ramstate = FREE;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Scoreboard: one entry per grant, describing the completion cycle the
    // requester must see and what the RAM port must carry at that moment.
    typedef struct {
        int    id;
        int    cyc;
        word_t addr;
        logic  wen;
        logic  ren;
        word_t store;
        word_t load;
    } exp_t;

    exp_t  sb_q[$];
    bit    sb_on    = 1'b0;
    bit    sat      = 1'b0;
    bit    rr_count = 1'b0;
    int    rr_cnt [N];
    int    cyc      = 0;
    bit    m_busy   = 1'b0;
    int    m_g      = 0;
    int    m_ptr    = 0;
    int    m_done   = 0;
    word_t m_load   = '0;
    int    served   = -1;

    function automatic int rr_ref(input int p);
        for (int k = 0; k < N; k++)
            if (t_req[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic new_request(input int r);
        t_req[r]  = 1'b1;
        t_wr[r]   = (r % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        t_both[r] = t_wr[r] & 1'($urandom_range(0, 1));
        t_addr[r] = $urandom;
        t_data[r] = $urandom;
    endtask

    // Called right at a rising edge, using the request values of the cycle just ended.
    task automatic model_edge();
        int   g;
        int   lat;
        exp_t e;
        served = -1;
        if (m_busy) begin
            if (cyc == m_done) begin
                m_ptr  = (m_g + 1) % N;
                m_busy = 1'b0;
                served = m_g;
            end
        end else begin
            g = rr_ref(m_ptr);
            if (g >= 0) begin
                lat     = sat ? 1 : int'($urandom_range(1, 4));
                m_g     = g;
                m_busy  = 1'b1;
                m_done  = cyc + lat;
                m_load  = $urandom;
                e.id    = g;
                e.cyc   = m_done;
                e.addr  = t_addr[g];
                e.wen   = (g % 2 == 0) && t_wr[g];
                e.ren   = (g % 2 == 0) ? !t_wr[g] : 1'b1;
                e.store = (g % 2 == 0) ? t_data[g] : '0;
                e.load  = m_load;
                sb_q.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic drive_cycle(input bit raise_on);
        if (served >= 0) begin
            t_req[served] = 1'b0;
            if (sat) new_request(served);
        end
        if (raise_on)
            for (int r = 0; r < N; r++)
                if (!t_req[r] && (sat || $urandom_range(0, 3) == 0)) new_request(r);
        if (m_busy && cyc == m_done) begin
            ramstate = ACCESS;
            ramload  = m_load;
        end else begin
            case ($urandom_range(0, 2))
                0:       ramstate = FREE;
                1:       ramstate = BUSY;
                default: ramstate = ERROR;
            endcase
            ramload = $urandom;
        end
    endtask

    always @(negedge CLK) begin : monitor
        int    low_n;
        int    low_id;
        exp_t  e;
        word_t [CPUS-1:0] ed;
        word_t [CPUS-1:0] ei;
        if (sb_on) begin
            low_n  = 0;
            low_id = -1;
            for (int c = 0; c < CPUS; c++) begin
                if (!dwait[c]) begin low_n++; low_id = 2*c;   end
                if (!iwait[c]) begin low_n++; low_id = 2*c+1; end
            end
            if (low_n != 0) begin
                check("one_wait_low", low_n, 1);
                if (sb_q.size() == 0) begin
                    check("completion_expected", low_n, 0);
                end else begin
                    e  = sb_q.pop_front();
                    ed = '0;
                    ei = '0;
                    if (e.id % 2 == 0) ed[e.id/2] = e.load;
                    else               ei[e.id/2] = e.load;
                    check("grant_id",  low_id, e.id);
                    check("done_cyc",  cyc, e.cyc);
                    check("ramaddr",   ramaddr, e.addr);
                    check("ramWEN",    ramWEN, e.wen);
                    check("ramREN",    ramREN, e.ren);
                    check("ramstore",  ramstore, e.store);
                    check("dload",     dload, ed);
                    check("iload",     iload, ei);
                    if (rr_count && low_id >= 0) rr_cnt[low_id]++;
                end
            end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                check("completion_due", low_n, 1);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        bit drained;
        clear_reqs();
        for (int r = 0; r < N; r++) begin
            t_addr[r] = '0;
            t_data[r] = '0;
            rr_cnt[r] = 0;
        end
        ramload  = '0;
        ramstate = BUSY;
        RST      = 1'b1;

        // Reset held with every requester asking; d0 is a write.
        for (int r = 0; r < N; r++) t_req[r] = 1'b1;
        t_wr[0]   = 1'b1;
        t_addr[0] = 32'h0000_0A00;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            check("reset_waits", {iwait, dwait}, 4'hF);
            check("reset_ram_en", {ramREN, ramWEN}, 2'b00);
            check("reset_loads", {iload, dload}, '0);
        end
        RST = 1'b0;
        @(negedge CLK);
        check("first_grant_d0_addr", ramaddr, 32'h0000_0A00);
        check("first_grant_d0_wen", ramWEN, 1'b1);
        reset_dut();

        // Single icache read, ACCESS on the second XFER cycle.
        t_req[1]  = 1'b1;
        t_addr[1] = 32'h0000_0040;
        ramstate  = BUSY;
        tick();
        @(negedge CLK);
        check("i0_xfer_ren", ramREN, 1'b1);
        check("i0_xfer_addr", ramaddr, 32'h0000_0040);
        check("i0_stall", iwait, 2'b11);
        tick();
        ramstate = ACCESS;
        ramload  = 32'hDEAD_BEEF;
        @(negedge CLK);
        check("i0_done_iwait", iwait, 2'b10);
        check("i0_done_iload0", iload[0], 32'hDEAD_BEEF);
        check("i0_done_iload1", iload[1], 32'h0);
        check("i0_done_dwait", dwait, 2'b11);
        check("i0_done_dload", dload, '0);
        tick();
        t_req[1] = 1'b0;
        ramstate = BUSY;
        ramload  = 32'h5555_AAAA;
        @(negedge CLK);
        check("i0_iwait_one_cycle", iwait, 2'b11);
        check("idle_ram_en", {ramREN, ramWEN}, 2'b00);

        // dcache 1 with both enables: a write must win.
        t_req[2]  = 1'b1;
        t_wr[2]   = 1'b1;
        t_both[2] = 1'b1;
        t_addr[2] = 32'h0000_0100;
        t_data[2] = 32'h0000_1234;
        tick();
        @(negedge CLK);
        check("wprio_wen", ramWEN, 1'b1);
        check("wprio_ren", ramREN, 1'b0);
        check("wprio_addr", ramaddr, 32'h0000_0100);
        check("wprio_store", ramstore, 32'h0000_1234);
        tick();
        ramstate = ACCESS;
        @(negedge CLK);
        check("wprio_dwait", dwait, 2'b01);
        tick();
        clear_reqs();
        ramstate = ERROR;

        // ERROR stall on d0, then reset mid-transfer.
        @(negedge CLK);
        t_req[0]  = 1'b1;
        t_addr[0] = 32'h0000_0200;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("stall_dwait", {iwait, dwait}, 4'hF);
            check("stall_ren", ramREN, 1'b1);
            if (k < 4) tick();
        end
        RST = 1'b1;
        tick();
        @(negedge CLK);
        check("midreset_ram_en", {ramREN, ramWEN}, 2'b00);
        check("midreset_waits", {iwait, dwait}, 4'hF);
        RST      = 1'b0;
        t_req[0] = 1'b0;
        t_req[1] = 1'b1;
        t_addr[1] = 32'h0000_1111;
        t_req[3] = 1'b1;
        t_addr[3] = 32'h0000_3333;
        ramstate = BUSY;
        tick();
        @(negedge CLK);
        check("post_reset_ptr0", ramaddr, 32'h0000_1111);
        tick();
        ramstate = ACCESS;
        @(negedge CLK);
        check("post_reset_done", iwait, 2'b10);
        tick();
        t_req[1] = 1'b0;
        ramstate = BUSY;

        // i1 granted, then withdrawn before ACCESS.
        tick();
        @(negedge CLK);
        check("wd_grant_i1", ramaddr, 32'h0000_3333);
        tick();
        t_req[3] = 1'b0;
        @(negedge CLK);
        check("wd_iwait_held", {iwait, dwait}, 4'hF);
        tick();
        t_req[0]  = 1'b1;
        t_addr[0] = 32'h0000_A0A0;
        t_req[2]  = 1'b1;
        t_addr[2] = 32'h0000_B0B0;
        ramstate  = ACCESS;
        @(negedge CLK);
        check("wd_idle_ram_en", {ramREN, ramWEN}, 2'b00);
        check("wd_idle_waits", {iwait, dwait}, 4'hF);
        tick();
        ramstate = BUSY;
        @(negedge CLK);
        check("wd_rescan_ptr", ramaddr, 32'h0000_B0B0);
        reset_dut();

        // Saturated round-robin with immediate ACCESS, then random traffic.
        sb_q.delete();
        m_busy   = 1'b0;
        m_ptr    = 0;
        cyc      = 0;
        sat      = 1'b1;
        sb_on    = 1'b1;
        for (int r = 0; r < N; r++) new_request(r);
        rr_count = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            model_edge();
            #1;
            drive_cycle(1'b1);
        end
        @(negedge CLK);
        rr_count = 1'b0;
        for (int r = 0; r < N; r++) check($sformatf("rr_share_%0d", r), rr_cnt[r], 5);

        sat = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge CLK);
            model_edge();
            #1;
            drive_cycle(1'b1);
        end

        drained = 1'b0;
        for (int k = 0; k < 300 && !drained; k++) begin
            @(posedge CLK);
            model_edge();
            #1;
            drive_cycle(1'b0);
            drained = !m_busy && (rr_ref(0) < 0);
        end
        @(negedge CLK);
        @(negedge CLK);
        check("drain_in_budget", drained, 1'b1);
        check("scoreboard_empty", sb_q.size(), 0);
        sb_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
